// File: rtl/text_console_pkg.sv
// text_console_pkg: shared states, control codes and geometry for text_console_ctrl (scroll states exist only with TEXT_CONSOLE_SCROLL_EN)
package text_console_pkg;
`ifdef TEXT_CONSOLE_SCROLL_EN
  typedef enum logic [1:0] {CLEAR, IDLE, SCROLL_COPY, SCROLL_FILL} state_t;
`else
  typedef enum logic [1:0] {CLEAR, IDLE} state_t;
`endif
  localparam logic [7:0] CHAR_BS   = 8'h08;
  localparam logic [7:0] CHAR_LF   = 8'h0A;
  localparam logic [7:0] CHAR_FF   = 8'h0C;
  localparam logic [7:0] CHAR_CR   = 8'h0D;
  localparam logic [7:0] PRINT_MIN = 8'h20;
  localparam logic [7:0] PRINT_MAX = 8'h7E;
  localparam int ROWS  = 4;
  localparam int COLS  = 16;
  localparam int CELLS = 64;
  function automatic logic is_print(input logic [7:0] c);
    return c >= PRINT_MIN && c <= PRINT_MAX;
  endfunction
endpackage

// File: rtl/text_console_mem.sv
// text_console_mem: 64x8 cell store, sync write (clk_i, we_i, waddr_i, wdata_i), async renderer read (raddr_a_i/rdata_a_o) and, with TEXT_CONSOLE_SCROLL_EN, async scroll-source read (raddr_b_i/rdata_b_o)
module text_console_mem
  import text_console_pkg::*;
(
  input  logic       clk_i,
  input  logic       we_i,
  input  logic [5:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [5:0] raddr_a_i,
  output logic [7:0] rdata_a_o
`ifdef TEXT_CONSOLE_SCROLL_EN
  ,
  input  logic [5:0] raddr_b_i,
  output logic [7:0] rdata_b_o
`endif
);
  logic [7:0] cells [CELLS];
  always_ff @(posedge clk_i)
    if (we_i) cells[waddr_i] <= wdata_i;
  assign rdata_a_o = cells[raddr_a_i];
`ifdef TEXT_CONSOLE_SCROLL_EN
  assign rdata_b_o = cells[raddr_b_i];
`endif
endmodule

// File: rtl/text_console_ctrl.sv
// text_console_ctrl: 4x16 console buffer writer; byte in (char_valid_i/char_i/char_ready_o), renderer read (char_address_i/char_data_o), cursor_o, busy_o; TEXT_CONSOLE_SCROLL_EN scrolls on wrap, else wraps cursor to 0
module text_console_ctrl
  import text_console_pkg::*;
#(
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       char_valid_i,
  input  logic [7:0] char_i,
  output logic       char_ready_o,
  input  logic [5:0] char_address_i,
  output logic [7:0] char_data_o,
  output logic [5:0] cursor_o,
  output logic       busy_o
);
  state_t state, state_n;
  logic [5:0] cnt, cnt_n, cur_n, waddr;
  logic [7:0] wdata;
  logic we, wrap, acc;
  logic [1:0] row;
  logic [3:0] col;
  assign acc = char_valid_i && char_ready_o;
  assign row = cursor_o[5:4];
  assign col = cursor_o[3:0];
`ifdef TEXT_CONSOLE_SCROLL_EN
  logic [7:0] src_data;
  logic [5:0] src_addr;
  assign src_addr = cnt + 6'(COLS);
`endif
  text_console_mem u_mem (
    .clk_i     (clk_i),
    .we_i      (we),
    .waddr_i   (waddr),
    .wdata_i   (wdata),
    .raddr_a_i (char_address_i),
    .rdata_a_o (char_data_o)
`ifdef TEXT_CONSOLE_SCROLL_EN
    ,
    .raddr_b_i (src_addr),
    .rdata_b_o (src_data)
`endif
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= CLEAR;
      cnt          <= '0;
      cursor_o     <= '0;
      char_ready_o <= 1'b0;
      busy_o       <= 1'b1;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      cursor_o     <= cur_n;
      char_ready_o <= state_n == IDLE;
      busy_o       <= state_n != IDLE;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cur_n   = cursor_o;
    we      = 1'b0;
    waddr   = cnt;
    wdata   = FILL_CHAR;
    wrap    = 1'b0;
    case (state)
      CLEAR: begin
        we    = 1'b1;
        cnt_n = cnt + 6'd1;
        if (cnt == 6'(CELLS - 1)) begin
          state_n = IDLE;
          cur_n   = '0;
        end
      end
      IDLE: if (acc) begin
        if (is_print(char_i)) begin
          we    = 1'b1;
          waddr = cursor_o;
          wdata = char_i;
          cur_n = cursor_o + 6'd1;
          wrap  = cursor_o == 6'(CELLS - 1);
        end else if (char_i == CHAR_CR) begin
          cur_n = {row, 4'd0};
        end else if (char_i == CHAR_LF) begin
          cur_n = {row + 2'd1, 4'd0};
          wrap  = row == 2'(ROWS - 1);
        end else if (char_i == CHAR_BS && col != 4'd0) begin
          we    = 1'b1;
          waddr = cursor_o - 6'd1;
          cur_n = cursor_o - 6'd1;
        end else if (char_i == CHAR_FF) begin
          state_n = CLEAR;
          cnt_n   = '0;
          cur_n   = '0;
        end
        if (wrap) begin
`ifdef TEXT_CONSOLE_SCROLL_EN
          state_n = SCROLL_COPY;
          cnt_n   = '0;
          cur_n   = 6'(CELLS - COLS);
`else
          cur_n   = '0;
`endif
        end
      end
`ifdef TEXT_CONSOLE_SCROLL_EN
      SCROLL_COPY: begin
        we      = 1'b1;
        wdata   = src_data;
        cnt_n   = cnt == 6'(CELLS - COLS - 1) ? '0 : cnt + 6'd1;
        state_n = cnt == 6'(CELLS - COLS - 1) ? SCROLL_FILL : SCROLL_COPY;
      end
      SCROLL_FILL: begin
        we      = 1'b1;
        waddr   = {2'(ROWS - 1), cnt[3:0]};
        cnt_n   = cnt == 6'(COLS - 1) ? '0 : cnt + 6'd1;
        state_n = cnt == 6'(COLS - 1) ? IDLE : SCROLL_FILL;
      end
`endif
      default: state_n = CLEAR;
    endcase
  end
endmodule

// File: tb/tb_text_console_ctrl.sv
// tb_text_console_ctrl: directed checks of text_console_ctrl against a console-semantics model (honours TEXT_CONSOLE_SCROLL_EN)
module tb_text_console_ctrl;
  logic clk_i = 1'b0, rst_i, char_valid_i, char_ready_o, busy_o;
  logic [7:0] char_i, char_data_o;
  logic [5:0] char_address_i, cursor_o;
  always #5 clk_i = ~clk_i;
  text_console_ctrl dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .char_valid_i   (char_valid_i),
    .char_i         (char_i),
    .char_ready_o   (char_ready_o),
    .char_address_i (char_address_i),
    .char_data_o    (char_data_o),
    .cursor_o       (cursor_o),
    .busy_o         (busy_o)
  );
  int checks = 0, passed = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  logic [7:0] m [64];
  int mc = 0, bl = 0;
  bit pend_scroll = 0, mem_ok = 0, started = 0, took = 0;
  task model_wrap();
`ifdef TEXT_CONSOLE_SCROLL_EN
    bl = 64; pend_scroll = 1; mc = 48;
`else
    mc = 0;
`endif
  endtask
  always @(posedge clk_i) begin
    took = 0;
    if (rst_i) begin
      started = 1; bl = 64; pend_scroll = 0; mc = 0;
    end else if (bl > 0) begin
      bl--;
      if (bl == 0) begin
        for (int i = 0; i < 64; i++)
          m[i] = (pend_scroll && i < 48) ? m[i + 16] : 8'h20;
        mem_ok = 1;
      end
    end else if (char_valid_i) begin
      took = 1;
      if (char_i >= 8'h20 && char_i <= 8'h7E) begin
        m[mc] = char_i;
        if (mc == 63) model_wrap(); else mc++;
      end else if (char_i == 8'h0D) mc = mc - mc % 16;
      else if (char_i == 8'h0A) begin
        if (mc / 16 == 3) model_wrap(); else mc = (mc / 16 + 1) * 16;
      end else if (char_i == 8'h08) begin
        if (mc % 16 != 0) begin mc--; m[mc] = 8'h20; end
      end else if (char_i == 8'h0C) begin
        bl = 64; pend_scroll = 0; mc = 0;
      end
    end
  end
  always @(negedge clk_i) if (started) begin
    chk("busy", busy_o, bl > 0);
    chk("ready", char_ready_o, bl == 0);
    chk("cursor", cursor_o, mc);
    if (bl == 0 && mem_ok) chk($sformatf("data@%0d", char_address_i), char_data_o, m[char_address_i]);
  end
  task automatic tick();
    @(posedge clk_i); #2;
    char_address_i = char_address_i + 6'd1;
  endtask
  task automatic send(input logic [7:0] b);
    int n = 0;
    char_valid_i = 1'b1; char_i = b;
    do begin @(posedge clk_i); #2; n++; end while (!took && n < 300);
    chk($sformatf("accept_%0h", b), took, 1);
    char_valid_i = 1'b0;
    char_address_i = char_address_i + 6'd1;
  endtask
  task automatic wait_busy(input int exp, input string nm);
    int n = 0;
    @(negedge clk_i);
    while (busy_o === 1'b1 && n < 300) begin n++; @(negedge clk_i); end
    chk(nm, n, exp);
  endtask
  task automatic check_cell(input logic [5:0] a, input logic [7:0] e);
    @(posedge clk_i); #2;
    char_address_i = a;
    @(negedge clk_i);
    chk($sformatf("cell%0d", a), char_data_o, e);
  endtask
  task automatic check_cur(input int e);
    @(negedge clk_i);
    chk("cursor_lit", cursor_o, e);
  endtask
  task automatic sweep_fill();
    for (int a = 0; a < 64; a++) check_cell(6'(a), 8'h20);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst_i = 1'b1; char_valid_i = 1'b0; char_i = 8'h00; char_address_i = '0;
    repeat (2) @(posedge clk_i);
    #2 rst_i = 1'b0;
    wait_busy(64, "init_busy");
    chk("init_ready", char_ready_o, 1);
    check_cur(0);
    sweep_fill();
    send(8'h41); check_cell(0, 8'h41); check_cur(1);
    send(8'h0D); check_cur(0);
    send(8'h0A); check_cur(16);
    send(8'h08); check_cur(16);
    send(8'h0C); wait_busy(64, "ff_busy"); check_cur(0);
    send(8'h41); send(8'h42); send(8'h43); check_cur(3);
    send(8'h08); check_cur(2); check_cell(2, 8'h20); check_cell(1, 8'h42);
    send(8'h07); check_cur(2); check_cell(1, 8'h42);
    send(8'h0C); wait_busy(64, "ff2_busy");
    for (int i = 0; i < 64; i++) send(8'(8'h30 + i));
`ifdef TEXT_CONSOLE_SCROLL_EN
    wait_busy(64, "scroll_busy"); check_cur(48);
    check_cell(0, 8'h40); check_cell(47, 8'h6F); check_cell(48, 8'h20); check_cell(63, 8'h20);
`else
    wait_busy(0, "wrap_busy"); check_cur(0);
    send(8'h5A); check_cell(0, 8'h5A); check_cell(1, 8'h31);
    chk("wrap_no_busy", busy_o, 0); check_cur(1);
`endif
    send(8'h0C); wait_busy(64, "ff_full_busy"); check_cur(0); sweep_fill();
    send(8'h07); check_cur(0); check_cell(0, 8'h20);
`ifdef TEXT_CONSOLE_SCROLL_EN
    for (int i = 0; i < 64; i++) send(8'(8'h41 + i % 26));
`else
    send(8'h0C);
`endif
    repeat (20) tick();
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    wait_busy(64, "rst_busy"); check_cur(0); sweep_fill();
    send(8'h51);
    repeat (4) send(8'h0A);
`ifdef TEXT_CONSOLE_SCROLL_EN
    wait_busy(64, "lf_scroll_busy"); check_cur(48); check_cell(0, 8'h20);
`else
    check_cur(0); check_cell(0, 8'h51);
`endif
    repeat (4) tick();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
